// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for the dual-clock FIFO pointer handlers (write side and
// read side). Provides the default address width, the pointer width and
// Gray/binary conversion helpers.
//
// The helpers take and return 32-bit values so that any pointer width up to 32
// can use them: callers zero-extend the operand and truncate the result.
// Zero-extension is harmless for both conversions because the extra leading
// zeros contribute nothing to the XOR terms of the lower bits.
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int ADDRSIZE = 7;
    localparam int PTRW     = ADDRSIZE + 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of the Gray bits at and above its position.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_r2w.sv
// -----------------------------------------------------------------------------
// sync_r2w
// Two-flop synchroniser that carries the read domain's Gray pointer into the
// write clock domain. Only one bit of a Gray pointer changes per step, so a
// metastable capture resolves to either the old or the new pointer value.
//
// Ports
//   clk_i  : destination (write) clock
//   rst_i  : synchronous active-high reset, clears both stages
//   d_i    : asynchronous input pointer (Gray)
//   q_o    : synchronised pointer, two clk_i edges behind d_i
// -----------------------------------------------------------------------------
module sync_r2w #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q1_q;
    logic [WIDTH-1:0] q2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q1_q <= '0;
            q2_q <= '0;
        end else begin
            q1_q <= d_i;
            q2_q <= q1_q;
        end
    end

    assign q_o = q2_q;

endmodule

// File: rtl/wptr_full.sv
// -----------------------------------------------------------------------------
// wptr_full
// Write-side pointer and status handler of the dual-clock FIFO. Owns the
// binary write address and the Gray write pointer exported to the read
// domain, synchronises the read pointer into wr_clk and produces full,
// almost-full, occupancy and a sticky overflow flag.
//
// Ports
//   wr_clk        : write clock (only clock in this block)
//   wr_rst        : synchronous active-high reset
//   wr_en         : producer write request
//   wr_rptr       : Gray read pointer from the read domain (asynchronous)
//   wclken        : memory write strobe, wr_en & ~wfull (combinational)
//   waddr         : memory write address for the current cycle
//   wptr          : registered Gray write pointer to the read domain
//   wfull         : registered full flag
//   walmost_full  : registered flag, occupancy >= AFULL_THRESH
//   wcount        : registered occupancy, 0 .. 2^ADDRSIZE
//   woverflow     : sticky, set by a write request while full
//
// Status is computed from the post-write pointer and a read pointer that is
// two edges old, so it can only overstate occupancy, never understate it.
// -----------------------------------------------------------------------------
module wptr_full #(
    parameter int ADDRSIZE     = fifo_pkg::ADDRSIZE,
    parameter int AFULL_THRESH = (2 ** ADDRSIZE) - 4
) (
    input  logic                wr_clk,
    input  logic                wr_rst,
    input  logic                wr_en,
    input  logic [ADDRSIZE:0]   wr_rptr,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wcount,
    output logic                woverflow
);

    import fifo_pkg::bin2gray;
    import fifo_pkg::gray2bin;

    localparam int A  = ADDRSIZE;
    localparam int PW = ADDRSIZE + 1;

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wcount_q, wcount_d;
    logic          wfull_q, wfull_d;
    logic          wafull_q, wafull_d;
    logic          wovf_q, wovf_d;

    logic [PW-1:0] wq2_rptr;
    logic [PW-1:0] rbin_s;
    logic          winc;

    sync_r2w #(.WIDTH(PW)) u_sync_r2w (
        .clk_i (wr_clk),
        .rst_i (wr_rst),
        .d_i   (wr_rptr),
        .q_o   (wq2_rptr)
    );

    assign winc   = wr_en & ~wfull_q;
    assign rbin_s = PW'(gray2bin(32'(wq2_rptr)));

    always_comb begin
        wbin_d   = wbin_q + PW'(winc);
        wptr_d   = PW'(bin2gray(32'(wbin_d)));
        // Modular difference: valid because the write side never runs more
        // than 2^A ahead of the (stale) read pointer.
        wcount_d = wbin_d - rbin_s;
        // Full when the pointers match except for the top two Gray bits,
        // i.e. the binary pointers differ by exactly 2^A.
        wfull_d  = (wptr_d == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]});
        wafull_d = (wcount_d >= PW'(AFULL_THRESH));
        wovf_d   = wovf_q | (wr_en & wfull_q);
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wcount_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wcount_q <= wcount_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign wclken       = winc;
    assign waddr        = wbin_q[A-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wcount       = wcount_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// -----------------------------------------------------------------------------
// tb_wptr_full
// Self-checking bench for wptr_full (ADDRSIZE=7, AFULL_THRESH=124).
// A behavioural model tracks the total number of accepted writes and the read
// pointer values the write side can legally see (two edges old), derives the
// expected outputs arithmetically, and a negedge process compares every cycle.
// Directed phases pin the model with literal expectations.
// -----------------------------------------------------------------------------
module tb_wptr_full;

    localparam int A  = 7;
    localparam int D  = 128;
    localparam int TH = 124;

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       wr_en;
    logic [7:0] wr_rptr;
    logic       wclken;
    logic [6:0] waddr;
    logic [7:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [7:0] wcount;
    logic       woverflow;

    wptr_full #(.ADDRSIZE(A), .AFULL_THRESH(TH)) dut (
        .wr_clk       (wr_clk),
        .wr_rst       (wr_rst),
        .wr_en        (wr_en),
        .wr_rptr      (wr_rptr),
        .wclken       (wclken),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .woverflow    (woverflow)
    );

    always #5 wr_clk = ~wr_clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic int b2g(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input int g);
        int b = g;
        int s = g >> 1;
        while (s != 0) begin
            b = b ^ s;
            s = s >> 1;
        end
        return b;
    endfunction

    // ---------------- behavioural model ----------------
    int m_total = 0;        // accepted writes since reset (unwrapped)
    int m_cnt   = 0;
    bit m_full  = 0;
    bit m_af    = 0;
    bit m_ovf   = 0;
    int hist[$];            // read pointers sampled on each edge since reset

    always @(posedge wr_clk) begin
        if (wr_rst) begin
            m_total = 0; m_cnt = 0; m_full = 0; m_af = 0; m_ovf = 0;
            hist.delete();
        end else begin
            int seen;
            seen = (hist.size() >= 2) ? hist[hist.size()-2] : 0;
            if (wr_en && m_full) m_ovf = 1;
            if (wr_en && !m_full) m_total++;
            m_cnt  = ((m_total % 256) - g2b(seen) + 256) % 256;
            m_full = (m_cnt == D);
            m_af   = (m_cnt >= TH);
            hist.push_back(int'(wr_rptr));
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    // ---------------- every-cycle compare ----------------
    always @(negedge wr_clk) begin
        if (chk_en) begin
            chk("wclken",       wclken,       (wr_en && !m_full) ? 1 : 0);
            chk("waddr",        waddr,        m_total % D);
            chk("wptr",         wptr,         b2g(m_total % 256));
            chk("wcount",       wcount,       m_cnt);
            chk("wfull",        wfull,        m_full);
            chk("walmost_full", walmost_full, m_af);
            chk("woverflow",    woverflow,    m_ovf);
        end
    end

    task automatic cyc();
        @(posedge wr_clk);
        #2;
    endtask

    int  rd;
    int  maxc;
    bit  saw_full, saw_wrap;
    logic [7:0] prev_w;

    initial begin
        wr_rst = 1'b1; wr_en = 1'b1; wr_rptr = '0;
        // reset with wr_en held
        cyc(); chk_en = 1'b1; cyc(); cyc();
        chk("rst_wptr", wptr, 0);
        chk("rst_wcount", wcount, 0);
        chk("rst_flags", {wfull, walmost_full, woverflow}, 0);
        chk("rst_waddr", waddr, 0);

        // back-to-back fill with read pointer at 0
        wr_rst = 1'b0;
        repeat (124) cyc();
        chk("fill124_cnt", wcount, 124);
        chk("fill124_af", walmost_full, 1);
        chk("fill124_full", wfull, 0);
        chk("model_cnt124", m_cnt, 124);
        repeat (4) cyc();
        chk("fill128_full", wfull, 1);
        chk("fill128_cnt", wcount, 128);
        chk("fill128_wptr", wptr, 8'hC0);

        // blocked write while full
        #1;
        chk("blocked_wclken", wclken, 0);
        chk("blocked_waddr", waddr, 0);
        cyc();
        chk("ovf_set", woverflow, 1);
        chk("blocked_wptr", wptr, 8'hC0);
        chk("blocked_cnt", wcount, 128);

        // one read while full
        wr_en = 1'b0; wr_rptr = 8'h01;
        cyc(); cyc();
        chk("read_pessimistic_full", wfull, 1);
        cyc();
        chk("read_full_clear", wfull, 0);
        chk("read_cnt127", wcount, 127);
        wr_en = 1'b1; #1;
        chk("read_then_accept", wclken, 1);
        cyc();
        chk("refill_cnt", wcount, 128);
        chk("refill_waddr", waddr, 1);
        chk("ovf_sticky", woverflow, 1);
        wr_en = 1'b0;

        // drain to 50 (129 written, read pointer 79), then reset mid-operation
        wr_rptr = 8'(b2g(79));
        repeat (3) cyc();
        chk("mid_cnt50", wcount, 50);
        chk("mid_ovf", woverflow, 1);
        wr_rst = 1'b1;
        cyc();
        chk("midrst_zero", {wptr, wcount, waddr, wfull, walmost_full, woverflow}, 0);
        wr_rst = 1'b0; wr_rptr = '0; wr_en = 1'b1; #1;
        chk("resume_waddr", waddr, 0);
        chk("resume_wclken", wclken, 1);
        cyc();
        chk("resume_waddr1", waddr, 1);
        chk("resume_cnt1", wcount, 1);

        // wrap: 300 writes each followed by a matching read advance
        wr_rst = 1'b1; wr_en = 1'b0; cyc();
        wr_rst = 1'b0; rd = 0; maxc = 0; saw_full = 0; saw_wrap = 0; prev_w = wptr;
        for (int i = 0; i < 300; i++) begin
            wr_en = 1'b1;
            for (int j = 0; j < 4; j++) begin
                cyc();
                if (j == 0) begin
                    wr_en = 1'b0; rd++; wr_rptr = 8'(b2g(rd % 256));
                end
                if (wfull) saw_full = 1;
                if (int'(wcount) > maxc) maxc = int'(wcount);
                if (prev_w == 8'h80 && wptr == 8'h00) saw_wrap = 1;
                prev_w = wptr;
            end
        end
        chk("wrap_seen", saw_wrap, 1);
        chk("wrap_no_full", saw_full, 0);
        chk("wrap_cnt_le1", (maxc <= 1) ? 1 : 0, 1);
        chk("wrap_total", m_total, 300);

        // randomized traffic: slow reader first (fills, overflows), then fast
        wr_rst = 1'b1; cyc(); wr_rst = 1'b0; rd = 0; wr_rptr = '0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                wr_rst = 1'b1; rd = 0; wr_rptr = '0;
            end else begin
                int adv;
                wr_rst = 1'b0;
                wr_en  = ($urandom_range(0, 3) != 0);
                adv = (i < 1500) ? (($urandom_range(0, 1) == 0) ? 1 : 0)
                                 : int'($urandom_range(0, 2));
                if (adv > m_total - rd) adv = m_total - rd;
                rd += adv;
                wr_rptr = 8'(b2g(rd % 256));
            end
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wptr_full.md
# wptr_full

Write-side pointer and status handler for the dual-clock FIFO; the write-domain counterpart of the read-pointer/empty logic. It owns the binary write address and the Gray-coded write pointer exported to the read domain. It synchronises the read domain's Gray pointer into `wr_clk` and derives the full, almost-full, occupancy and overflow status that the producer consumes.

## Interface
- `ADDRSIZE`, 7: FIFO depth is 2^ADDRSIZE. Pointers are ADDRSIZE+1 bits (extra wrap bit).
- `AFULL_THRESH`, 2^ADDRSIZE-4: `walmost_full` asserts when occupancy >= this value. Legal range 1..2^ADDRSIZE.
- `wr_clk`  in  1  write-domain clock; the only clock in this block.
- `wr_rst`  in  1  reset, synchronous, active-high.
- `wr_en`  in  1  write request from the producer.
- `wr_rptr`  in  ADDRSIZE+1  Gray read pointer, raw from the read domain (asynchronous to `wr_clk`).
- `wclken`  out  1  memory write strobe, combinational: `wr_en & ~wfull`.
- `waddr`  out  ADDRSIZE  memory write address, `wbin[ADDRSIZE-1:0]`.
- `wptr`  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- `wfull`  out  1  registered full flag.
- `walmost_full`  out  1  registered almost-full flag.
- `wcount`  out  ADDRSIZE+1  registered occupancy as seen by the write side, 0..2^ADDRSIZE.
- `woverflow`  out  1  sticky flag: a write was attempted while full.

## Operation
- Accept: `winc = wr_en & ~wfull`. `wbinnext = wbin + winc`, modulo 2^(ADDRSIZE+1). `wgraynext = (wbinnext>>1) ^ wbinnext`.
- Each cycle, register `{wbin, wptr} <= {wbinnext, wgraynext}`.
- Synchronisation: `wr_rptr` passes through two flops, `wq1_rptr` then `wq2_rptr`. No other logic may sample `wr_rptr` directly.
- Full: `wfull <= (wgraynext == {~wq2_rptr[A:A-1], wq2_rptr[A-2:0]})`, where A = ADDRSIZE.
- Occupancy:
  - `rbin_s = gray2bin(wq2_rptr)`.
  - `wcount <= wbinnext - rbin_s`, computed in ADDRSIZE+1 bits with modular wrap.
  - `walmost_full <= (wbinnext - rbin_s) >= AFULL_THRESH`.
- Overflow: `wr_en & wfull` sets `woverflow`. It stays set until reset. Blocked writes change no pointer, address or count.
- Wrap-around: `wbin` rolls from 2^(A+1)-1 to 0 with no special case. Gray adjacency is preserved across the wrap.
- Simultaneous write and read-pointer advance: both apply. The read advance is seen with synchroniser delay, so flags are pessimistic and never optimistic.
- Reset: every register clears on the first `wr_clk` edge with `wr_rst` high, including the synchroniser flops.
  - Reset values: `wbin`=0, `wptr`=0, `wq1/wq2`=0, `wfull`=0, `walmost_full`=0, `wcount`=0, `woverflow`=0.
  - Reset mid-operation abandons all state. The read domain must be reset in the same window.

## Timing
- `wclken` is combinational in the same cycle as `wr_en`. `waddr` is valid in that cycle and is the address for the accepted word.
- `wptr`, `wcount`, `wfull` and `walmost_full` reflect an accepted write on the next `wr_clk` edge (latency 1).
- The 2^ADDRSIZE-th consecutive accepted write makes `wfull` assert at the next edge. A `wr_en` in that following cycle is blocked.
- Read-pointer latency: a `wr_rptr` change captured at edge N reaches `wq2_rptr` at N+1. Flags and count update at N+2. Allow 3 edges when `wr_rptr` is asynchronous.
- `woverflow` asserts one edge after the blocked request.

## Structure
- Shared package `fifo_pkg`:
  - default `ADDRSIZE`;
  - functions `bin2gray` and `gray2bin` (width-parameterised);
  - pointer-width localparam `PTRW = ADDRSIZE+1`.
  - The read-side handler uses the same package.
- One sub-module, `sync_r2w`: a two-flop synchroniser with parameter `WIDTH` and synchronous active-high reset. This module is the only place `wr_rptr` enters the domain.
- Everything else stays in `wptr_full`.

## Test plan
All scenarios use `ADDRSIZE`=7 and `AFULL_THRESH`=124.
- Reset with `wr_en`=1 held: every output is 0 and `waddr`=0. `wclken`=1 is permitted but `wbin` does not advance while `wr_rst`=1.
- 128 back-to-back writes with `wr_rptr`=0:
  - `walmost_full`=1 after the 124th write, `wcount`=124.
  - `wfull`=1 after the 128th write, `wcount`=128, `wptr`=8'hC0.
- Write attempt while full: `wclken`=0, and `wptr`, `wcount` and `waddr` are unchanged. `woverflow`=1 one edge later and stays 1 until reset.
- While full, drive `wr_rptr`=8'h01 (one read): `wfull`=0 and `wcount`=127 exactly 2 edges after capture. The next write is accepted.
- Wrap: 300 writes interleaved with matching `wr_rptr` advances.
  - `wbin` wraps 255→0 and `wptr` goes 8'h80→8'h00.
  - `wfull` never asserts and `wcount` stays ≤1.
- Reset asserted at `wcount`=50 with `woverflow`=1: all outputs are 0 on the next edge. Normal writes resume from `waddr`=0.
